fetch_sequencer: RTL and testbench

- Sequences the instruction memory: owns the program counter and drives the word address into the 32-bit asynchronous-read instruction ROM.
- Captures each fetched word into a 2-entry instruction buffer and presents it to decode over a valid/ready handshake.
- Handles start, redirect (branch/jump) with flush, and halt-on-sentinel.
- Sits between the instruction memory and the decode stage of the CPU.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/instr_buffer.sv | 78 +++++++
 rtl/fetch_sequencer.sv | 91 +++++++++
 tb/tb_fetch_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch FSM state encoding
package cpu_pkg;

   localparam int          IMEM_ADDR_W = 6;
   localparam int          INSTR_W     = 32;
   localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

endpackage

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - 2-entry synchronous FIFO of {instr, pc} with registered head
module instr_buffer #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_instr,
   input  logic [PC_W-1:0]   push_pc,
   input  logic              pop,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head_instr,
   output logic [PC_W-1:0]   head_pc
);

   logic [DATA_W-1:0] instr_q [2];
   logic [DATA_W-1:0] instr_d [2];
   logic [PC_W-1:0]   pc_q    [2];
   logic [PC_W-1:0]   pc_d    [2];
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              do_pop, do_push;

   assign empty      = (count_q == 2'd0);
   assign full       = (count_q == 2'd2);
   assign head_instr = instr_q[rd_ptr_q];
   assign head_pc    = pc_q[rd_ptr_q];

   // When full, a push is only accepted alongside a pop; the write lands in the slot being vacated.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      instr_d  = instr_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         if (do_push) begin
            instr_d[wr_ptr_q] = push_instr;
            pc_d[wr_ptr_q]    = push_pc;
            wr_ptr_d          = ~wr_ptr_q;
         end
         count_d = count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q[0] <= '0;
         instr_q[1] <= '0;
         pc_q[0]    <= '0;
         pc_q[1]    <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM, program counter and decode handshake
module fetch_sequencer #(
   parameter int                 ADDR_W    = cpu_pkg::IMEM_ADDR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [31:0]        HALT_WORD = cpu_pkg::HALT_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic              busy
);

   import cpu_pkg::*;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              buf_full, buf_empty, flush, enq, pop;

   assign imem_addr = pc_q;
   assign out_valid = !buf_empty;
   assign halted    = (state_q == HALT);
   assign busy      = (state_q == RUN);
   assign pop       = out_valid && out_ready;
   // Redirect wins over the fetch in the same cycle.
   assign enq       = (state_q == RUN) && !redirect && (!buf_full || pop);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush   = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
               flush   = 1'b1;
            end
         end
         RUN: begin
            if (redirect) begin
               pc_d  = redirect_pc;
               flush = 1'b1;
            end else if (enq) begin
               if (imem_dout == HALT_WORD) begin
                  state_d = HALT;
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   instr_buffer #(
      .DATA_W (32),
      .PC_W   (ADDR_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (enq),
      .push_instr (imem_dout),
      .push_pc    (pc_q),
      .pop        (pop),
      .flush      (flush),
      .full       (buf_full),
      .empty      (buf_empty),
      .head_instr (out_instr),
      .head_pc    (out_pc)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench for fetch_sequencer with a behavioural ROM
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  imem_addr;
   logic [31:0] imem_dout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [5:0]  out_pc;
   logic        redirect;
   logic [5:0]  redirect_pc;
   logic        halted;
   logic        busy;

   logic [31:0] rom [64];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   assign imem_dout = rom[imem_addr];

   fetch_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .imem_addr   (imem_addr),
      .imem_dout   (imem_dout),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] instr, input logic [5:0] pc);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_instr"}, out_instr, instr);
      chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h10 + 32'(i);
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      step(); step();
      rst = 1'b0;

      // reset state
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", 32'(out_pc), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      step();
      chk("idle_addr", 32'(imem_addr), 32'd0);

      // basic stream
      out_ready = 1'b1;
      do_start();
      chk("bs_busy", 32'(busy), 32'd1);
      chk("bs_valid0", 32'(out_valid), 32'd0);
      chk("bs_addr0", 32'(imem_addr), 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk_head("bs", 32'h10 + 32'(i), 6'(i));
         step();
      end

      // backpressure
      do_reset();
      out_ready = 1'b0;
      do_start();
      step();
      for (int i = 0; i < 5; i++) begin
         chk_head("bp_hold", 32'h10, 6'd0);
         step();
      end
      chk("bp_addr", 32'(imem_addr), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head("bp_rel", 32'h10 + 32'(i), 6'(i));
         step();
      end

      // redirect with two entries buffered
      do_reset();
      out_ready = 1'b0;
      do_start();
      step(); step();
      chk("rd_addr_pre", 32'(imem_addr), 32'd2);
      redirect = 1'b1; redirect_pc = 6'd40;
      step();
      redirect = 1'b0;
      chk("rd_valid_flush", 32'(out_valid), 32'd0);
      chk("rd_addr", 32'(imem_addr), 32'd40);
      step();
      out_ready = 1'b1;
      chk_head("rd0", 32'h38, 6'd40);
      step();
      chk_head("rd1", 32'h39, 6'd41);

      // halt on sentinel
      do_reset();
      rom[3] = 32'hFFFF_FFFF;
      out_ready = 1'b1;
      do_start();
      step();
      for (int i = 0; i < 4; i++) begin
         chk_head("ht", (i == 3) ? 32'hFFFF_FFFF : 32'h10 + 32'(i), 6'(i));
         if (i < 3) step();
      end
      chk("ht_halted", 32'(halted), 32'd1);
      chk("ht_busy", 32'(busy), 32'd0);
      chk("ht_addr", 32'(imem_addr), 32'd3);
      redirect = 1'b1; redirect_pc = 6'd20;
      step();
      redirect = 1'b0;
      chk("ht_drained", 32'(out_valid), 32'd0);
      chk("ht_addr_hold", 32'(imem_addr), 32'd3);
      chk("ht_halted2", 32'(halted), 32'd1);
      do_start();
      chk("ht_restart_busy", 32'(busy), 32'd1);
      chk("ht_restart_halted", 32'(halted), 32'd0);
      chk("ht_restart_addr", 32'(imem_addr), 32'd0);
      step();
      chk_head("ht_restart", 32'h10, 6'd0);
      rom[3] = 32'h13;

      // wrap-around
      do_reset();
      out_ready = 1'b1;
      do_start();
      step();
      redirect = 1'b1; redirect_pc = 6'd62;
      step();
      redirect = 1'b0;
      chk("wr_valid_flush", 32'(out_valid), 32'd0);
      step();
      chk_head("wr62", 32'h4E, 6'd62);
      step();
      chk_head("wr63", 32'h4F, 6'd63);
      step();
      chk_head("wr0", 32'h10, 6'd0);
      step();
      chk_head("wr1", 32'h11, 6'd1);

      // reset mid-run with a full buffer and a redirect
      do_reset();
      out_ready = 1'b0;
      do_start();
      step(); step();
      rst = 1'b1; redirect = 1'b1; redirect_pc = 6'd10;
      step();
      rst = 1'b0; redirect = 1'b0;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_valid", 32'(out_valid), 32'd0);
      chk("mr_addr", 32'(imem_addr), 32'd0);
      chk("mr_pc", 32'(out_pc), 32'd0);
      chk("mr_instr", out_instr, 32'd0);
      step(); step(); step();
      chk("mr_idle_valid", 32'(out_valid), 32'd0);
      chk("mr_idle_addr", 32'(imem_addr), 32'd0);
      chk("mr_idle_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
